// File: rtl/spi_host_cmd_pkg.sv
// SPI host command definitions: lane speeds, direction bits and
// the per-speed index of the last falling SCK edge in a byte.
package spi_host_cmd_pkg;

    typedef enum logic [1:0] {
        Standard = 2'd0,
        Dual     = 2'd1,
        Quad     = 2'd2,
        RsvdSpd  = 2'd3
    } spi_speed_e;

    localparam int unsigned DirTx = 1;
    localparam int unsigned DirRx = 0;

    // A byte spans 8/4/2 SCK periods depending on the lane count.
    function automatic logic [2:0] last_edge_idx(spi_speed_e spd);
        logic [2:0] idx;
        unique case (spd)
            Dual:    idx = 3'd3;
            Quad:    idx = 3'd1;
            default: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/spi_host_clk_div.sv
// SCK half-period divider; also times the CSB lead/trail windows.
// Edge pulses are combinational with the toggle they announce.
module spi_host_clk_div #(
    parameter int unsigned ClkDivW = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic               sck_en_i,
    input  logic               hold_i,
    input  logic [ClkDivW-1:0] clkdiv_i,
    output logic               sck_o,
    output logic               wrap_o,
    output logic               rise_o,
    output logic               fall_o
);

    logic [ClkDivW-1:0] cnt_q;
    logic               sck_q;

    assign wrap_o = en_i && (cnt_q == clkdiv_i);
    assign rise_o = wrap_o && sck_en_i && !sck_q;
    assign fall_o = wrap_o && sck_en_i && sck_q;
    assign sck_o  = sck_q;

    // A held edge keeps the count parked at clkdiv so it fires on release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (en_i && !hold_i) begin
            if (wrap_o) begin
                cnt_q <= '0;
                if (sck_en_i) begin
                    sck_q <= !sck_q;
                end
            end else begin
                cnt_q <= cnt_q + ClkDivW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_host_seq_fsm.sv
// SPI host segment sequencer: CSB framing, byte load/capture
// handshakes and shift/sample strobes for an external shift register.
module spi_host_seq_fsm
    import spi_host_cmd_pkg::*;
#(
    parameter int unsigned ClkDivW = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sw_rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [8:0]         cmd_len_i,
    input  logic [1:0]         cmd_speed_i,
    input  logic [1:0]         cmd_dir_i,
    input  logic               cmd_csaat_i,
    input  logic               cmd_full_cyc_i,
    input  logic [ClkDivW-1:0] clkdiv_i,
    output logic               sck_o,
    output logic               csb_o,
    output logic               wr_en_o,
    input  logic               wr_ready_i,
    output logic               rd_en_o,
    input  logic               rd_ready_i,
    output logic               shift_en_o,
    output logic               sample_en_o,
    output logic               full_cyc_o,
    output logic               last_write_o,
    output logic               last_read_o,
    output logic [1:0]         speed_o,
    output logic               active_o,
    output logic               err_o
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        LOAD,
        SHIFT,
        TRAIL
    } state_e;

    state_e             state_q, state_d;
    logic               csb_q, csb_d;
    logic               init_q;
    spi_speed_e         spd_q;
    logic [8:0]         len_q;
    logic [8:0]         byte_cnt_q, byte_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]         dir_q;
    logic               csaat_q;
    logic               fullcyc_q;
    logic [ClkDivW-1:0] clkdiv_q;

    logic cmd_ready, cap, wr_en, rd_en, stall, err;
    logic div_en, sck_en, div_wrap, div_rise, div_fall;
    logic last_byte, last_edge;

    assign cmd_ready = (state_q == IDLE) && init_q && !sw_rst_i;
    assign div_en    = (state_q inside {LEAD, SHIFT, TRAIL}) && !sw_rst_i;
    assign sck_en    = (state_q == SHIFT);
    assign last_byte = (byte_cnt_q == len_q);
    assign last_edge = (bit_cnt_q == last_edge_idx(spd_q));

    spi_host_clk_div #(
        .ClkDivW(ClkDivW)
    ) u_clk_div (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (sw_rst_i),
        .en_i     (div_en),
        .sck_en_i (sck_en),
        .hold_i   (stall),
        .clkdiv_i (clkdiv_q),
        .sck_o    (sck_o),
        .wrap_o   (div_wrap),
        .rise_o   (div_rise),
        .fall_o   (div_fall)
    );

    always_comb begin
        state_d    = state_q;
        csb_d      = csb_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        cap        = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        stall      = 1'b0;
        err        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready) begin
                    if (spi_speed_e'(cmd_speed_i) == RsvdSpd) begin
                        err = 1'b1;
                    end else begin
                        cap     = 1'b1;
                        csb_d   = 1'b0;
                        state_d = csb_q ? LEAD : LOAD;
                    end
                end
            end
            LEAD: begin
                if (div_wrap) state_d = LOAD;
            end
            LOAD: begin
                wr_en = dir_q[DirTx];
                if (wr_ready_i || !dir_q[DirTx]) state_d = SHIFT;
            end
            SHIFT: begin
                if (div_fall) begin
                    if (last_edge) begin
                        // Closing edge waits for the RX byte to be taken.
                        rd_en = dir_q[DirRx];
                        stall = rd_en && !rd_ready_i;
                        if (!stall) begin
                            bit_cnt_d = '0;
                            if (last_byte) begin
                                byte_cnt_d = '0;
                                state_d    = csaat_q ? IDLE : TRAIL;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 9'd1;
                                state_d    = LOAD;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            TRAIL: begin
                if (div_wrap) begin
                    state_d = IDLE;
                    csb_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (sw_rst_i) begin
            state_d    = IDLE;
            csb_d      = 1'b1;
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            cap        = 1'b0;
            wr_en      = 1'b0;
            rd_en      = 1'b0;
            stall      = 1'b0;
            err        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            csb_q      <= 1'b1;
            init_q     <= 1'b0;
            spd_q      <= Standard;
            len_q      <= '0;
            dir_q      <= '0;
            csaat_q    <= 1'b0;
            fullcyc_q  <= 1'b0;
            clkdiv_q   <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            csb_q      <= csb_d;
            init_q     <= 1'b1;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            if (cap) begin
                spd_q     <= spi_speed_e'(cmd_speed_i);
                len_q     <= cmd_len_i;
                dir_q     <= cmd_dir_i;
                csaat_q   <= cmd_csaat_i;
                fullcyc_q <= cmd_full_cyc_i;
                clkdiv_q  <= clkdiv_i;
            end
        end
    end

    assign cmd_ready_o  = cmd_ready;
    assign csb_o        = csb_q;
    assign wr_en_o      = wr_en;
    assign rd_en_o      = rd_en;
    assign last_write_o = wr_en && last_byte;
    assign last_read_o  = rd_en && last_byte;
    assign shift_en_o   = div_fall && !stall;
    assign sample_en_o  = div_rise && !fullcyc_q;
    assign full_cyc_o   = fullcyc_q;
    assign speed_o      = spd_q;
    assign active_o     = (state_q != IDLE);
    assign err_o        = err;

endmodule

// File: tb/tb_spi_host_seq_fsm.sv
// Scoreboard bench for spi_host_seq_fsm: stimulus queues expected
// handshake/segment events, a monitor pops and compares them.
module tb_spi_host_seq_fsm;

    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_ERR = 2;
    localparam int EV_SEG = 3;

    typedef struct {
        int kind;
        int last;
        int shifts;
        int samples;
        int rises;
        int hi_max;
        int csb_low;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        sw_rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [8:0]  cmd_len_i;
    logic [1:0]  cmd_speed_i;
    logic [1:0]  cmd_dir_i;
    logic        cmd_csaat_i;
    logic        cmd_full_cyc_i;
    logic [15:0] clkdiv_i;
    logic        sck_o, csb_o;
    logic        wr_en_o, wr_ready_i;
    logic        rd_en_o, rd_ready_i;
    logic        shift_en_o, sample_en_o, full_cyc_o;
    logic        last_write_o, last_read_o;
    logic [1:0]  speed_o;
    logic        active_o, err_o;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   n_shift, n_samp, n_rise, hi_run, hi_max, csb_run;
    bit   prev_act, prev_sck;

    spi_host_seq_fsm #(.ClkDivW(16)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sw_rst_i       (sw_rst_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_len_i      (cmd_len_i),
        .cmd_speed_i    (cmd_speed_i),
        .cmd_dir_i      (cmd_dir_i),
        .cmd_csaat_i    (cmd_csaat_i),
        .cmd_full_cyc_i (cmd_full_cyc_i),
        .clkdiv_i       (clkdiv_i),
        .sck_o          (sck_o),
        .csb_o          (csb_o),
        .wr_en_o        (wr_en_o),
        .wr_ready_i     (wr_ready_i),
        .rd_en_o        (rd_en_o),
        .rd_ready_i     (rd_ready_i),
        .shift_en_o     (shift_en_o),
        .sample_en_o    (sample_en_o),
        .full_cyc_o     (full_cyc_o),
        .last_write_o   (last_write_o),
        .last_read_o    (last_read_o),
        .speed_o        (speed_o),
        .active_o       (active_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic take(input int kind, input int last);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == EV_SEG && e.kind == EV_SEG) begin
                chk("seg_shift_en", n_shift, e.shifts);
                chk("seg_sample_en", n_samp, e.samples);
                chk("seg_sck_rises", n_rise, e.rises);
                chk("seg_sck_high_max", hi_max, e.hi_max);
                if (e.csb_low >= 0) chk("seg_csb_low", csb_run, e.csb_low);
            end else if (kind != EV_SEG) begin
                chk("event_last", last, e.last);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                if (wr_en_o && wr_ready_i) take(EV_WR, int'(last_write_o));
                if (rd_en_o && rd_ready_i) take(EV_RD, int'(last_read_o));
                if (err_o) take(EV_ERR, 0);
                if (prev_act && !active_o) begin
                    take(EV_SEG, 0);
                    n_shift = 0;
                    n_samp  = 0;
                    n_rise  = 0;
                    hi_max  = 0;
                end
                n_shift += int'(shift_en_o);
                n_samp  += int'(sample_en_o);
                if (sck_o && !prev_sck) n_rise++;
                hi_run  = sck_o ? hi_run + 1 : 0;
                if (hi_run > hi_max) hi_max = hi_run;
                csb_run = csb_o ? 0 : csb_run + 1;
                prev_sck = sck_o;
                prev_act = active_o;
            end else begin
                n_shift = 0; n_samp = 0; n_rise = 0;
                hi_run = 0; hi_max = 0; csb_run = 0;
                prev_sck = 1'b0; prev_act = 1'b0;
            end
        end
    endtask

    task automatic push_seg(input int len, input bit tx, input bit rx,
                            input int shifts, input int samples,
                            input int hi, input int csb);
        for (int b = 0; b <= len; b++) begin
            if (tx) exp_q.push_back('{EV_WR, int'(b == len), 0, 0, 0, 0, 0});
            if (rx) exp_q.push_back('{EV_RD, int'(b == len), 0, 0, 0, 0, 0});
        end
        exp_q.push_back('{EV_SEG, 0, shifts, samples, shifts, hi, csb});
    endtask

    task automatic send_cmd(input logic [8:0] len, input logic [1:0] spd,
                            input logic [1:0] dir, input logic csaat,
                            input logic fc, input logic [15:0] div);
        int n = 0;
        cmd_len_i      = len;
        cmd_speed_i    = spd;
        cmd_dir_i      = dir;
        cmd_csaat_i    = csaat;
        cmd_full_cyc_i = fc;
        clkdiv_i       = div;
        cmd_valid_i    = 1'b1;
        while (!cmd_ready_o && n < 100) begin
            tick();
            n++;
        end
        chk("cmd_accept", int'(cmd_ready_o), 1);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_events", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        rst_ni = 1'b0; sw_rst_i = 1'b0; cmd_valid_i = 1'b0;
        cmd_len_i = '0; cmd_speed_i = '0; cmd_dir_i = '0;
        cmd_csaat_i = 1'b0; cmd_full_cyc_i = 1'b0; clkdiv_i = '0;
        wr_ready_i = 1'b1; rd_ready_i = 1'b1;
        fork
            monitor();
        join_none

        #12;
        chk("rst_csb", int'(csb_o), 1);
        chk("rst_ready", int'(cmd_ready_o), 0);
        chk("rst_sck", int'(sck_o), 0);
        chk("rst_active", int'(active_o), 0);
        chk("rst_speed", int'(speed_o), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        #1;
        chk("ready_after_rel", int'(cmd_ready_o), 0);
        tick();
        chk("ready_one_clk", int'(cmd_ready_o), 1);
        mon_en = 1'b1;

        // Standard TX+RX, len 0, clkdiv 1: LEAD2+LOAD1+32+TRAIL2
        push_seg(0, 1, 1, 8, 8, 2, 37);
        send_cmd(9'd0, 2'd0, 2'd3, 1'b0, 1'b0, 16'd1);
        drain(200);

        // Quad RX-only, len 2, clkdiv 0: LEAD1+3*(LOAD1+4)+TRAIL1
        push_seg(2, 0, 1, 6, 6, 1, 17);
        send_cmd(9'd2, 2'd2, 2'd1, 1'b0, 1'b0, 16'd0);
        drain(200);

        // Dual TX, len 1, wr_ready low 5 clocks at byte 2
        push_seg(1, 1, 0, 8, 8, 2, 43);
        send_cmd(9'd1, 2'd1, 2'd2, 1'b0, 1'b0, 16'd1);
        n = 0;
        while (!wr_en_o && n < 50) begin tick(); n++; end
        tick();
        wr_ready_i = 1'b0;
        n = 0;
        while (!wr_en_o && n < 100) begin tick(); n++; end
        chk("wr_stall_reached", int'(wr_en_o), 1);
        for (int i = 0; i < 5; i++) begin
            chk("wr_stall_sck", int'(sck_o), 0);
            chk("wr_stall_shift", int'(shift_en_o), 0);
            tick();
        end
        wr_ready_i = 1'b1;
        drain(200);

        // RX full-cycle, rd_ready low at the closing edge for 3 clocks
        rd_ready_i = 1'b0;
        push_seg(0, 0, 1, 8, 0, 5, 40);
        send_cmd(9'd0, 2'd0, 2'd1, 1'b0, 1'b1, 16'd1);
        n = 0;
        while (!rd_en_o && n < 100) begin tick(); n++; end
        chk("rd_full_cyc", int'(full_cyc_o), 1);
        for (int i = 0; i < 3; i++) begin
            chk("rd_stall_sck", int'(sck_o), 1);
            chk("rd_stall_shift", int'(shift_en_o), 0);
            tick();
        end
        rd_ready_i = 1'b1;
        #1;
        chk("rd_en_with_shift", int'(rd_en_o && shift_en_o), 1);
        drain(200);

        // csaat segment, then a second command skips LEAD
        push_seg(0, 1, 1, 8, 8, 1, -1);
        send_cmd(9'd0, 2'd0, 2'd3, 1'b1, 1'b0, 16'd0);
        drain(200);
        chk("csaat_csb_low", int'(csb_o), 0);
        push_seg(0, 1, 0, 2, 2, 3, -1);
        send_cmd(9'd0, 2'd2, 2'd2, 1'b0, 1'b0, 16'd2);
        chk("no_lead_wr_en", int'(wr_en_o), 1);
        chk("no_lead_csb", int'(csb_o), 0);
        drain(200);
        chk("csaat_end_csb", int'(csb_o), 1);

        // Software reset in the middle of SHIFT
        mon_en = 1'b0;
        send_cmd(9'd3, 2'd0, 2'd3, 1'b0, 1'b0, 16'd1);
        repeat (6) tick();
        chk("swrst_pre_active", int'(active_o), 1);
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        #1;
        chk("swrst_csb", int'(csb_o), 1);
        chk("swrst_sck", int'(sck_o), 0);
        chk("swrst_active", int'(active_o), 0);
        chk("swrst_strobes", int'({shift_en_o, sample_en_o, wr_en_o, rd_en_o}), 0);
        chk("swrst_ready", int'(cmd_ready_o), 1);
        tick();
        mon_en = 1'b1;
        tick();

        // Reserved speed is rejected with a single err pulse
        exp_q.push_back('{EV_ERR, 0, 0, 0, 0, 0, 0});
        send_cmd(9'd0, 2'd3, 2'd3, 1'b0, 1'b0, 16'd1);
        chk("rsvd_csb", int'(csb_o), 1);
        chk("rsvd_active", int'(active_o), 0);
        repeat (3) tick();
        drain(10);

        // Asynchronous reset mid-segment
        mon_en = 1'b0;
        send_cmd(9'd1, 2'd1, 2'd3, 1'b0, 1'b1, 16'd1);
        n = 0;
        while (!sck_o && n < 50) begin tick(); n++; end
        chk("arst_in_shift", int'(sck_o), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_csb", int'(csb_o), 1);
        chk("arst_sck", int'(sck_o), 0);
        chk("arst_active", int'(active_o), 0);
        chk("arst_ready", int'(cmd_ready_o), 0);
        chk("arst_speed", int'(speed_o), 0);
        chk("arst_full_cyc", int'(full_cyc_o), 0);
        chk("arst_strobes", int'({shift_en_o, sample_en_o, wr_en_o, rd_en_o}), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        #1;
        chk("arst_ready_rel", int'(cmd_ready_o), 0);
        tick();
        chk("arst_ready_one_clk", int'(cmd_ready_o), 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
